retospect_lif_core: RTL

- Leaky integrate-and-fire compute core: the downstream consumer of the CNB configuration chain and the clockbox clockbus.
- Takes the CNB's shifted-in weights (w1..w4), threshold (uT) and decay select (clockDecaySelect), plus four neighbour spike inputs.
- Integrates a saturating signed membrane potential, leaks it on the selected clockbus tick, and emits a one-cycle spike with a refractory period.
- One instance per CNB; its spike output drives the neighbour spike inputs of adjacent cells and the outbus.

---
 rtl/retospect_lif_core.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/retospect_lif_core.sv
// Leaky integrate-and-fire core: saturating signed membrane potential, clockbus-driven leak, spike with refractory window.
// Latency: spike_in sampled at edge N drives spike_out and pot_out after edge N (one register stage).
// Backpressure: none; config_en freezes all state and suppresses spikes, reset_nn clears the network state.
module retospect_lif_core #(
  parameter int POT_W          = 6,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reset_nn,
  input  logic             config_en,
  input  logic [2:0]       w1,
  input  logic [2:0]       w2,
  input  logic [2:0]       w3,
  input  logic [2:0]       w4,
  input  logic [3:0]       uT,
  input  logic [2:0]       decay_sel,
  input  logic [7:0]       clockbus,
  input  logic [3:0]       spike_in,
  output logic             spike_out,
  output logic [POT_W-1:0] pot_out,
  output logic             busy
);

  // Arithmetic width: one guard bit above the larger of the potential and the
  // synaptic sum (-16..+12 needs 5 bits), plus one more so leak+sum never wraps
  // before saturation, even for narrow POT_W builds.
  localparam int EXT_W = ((POT_W > 5) ? POT_W : 5) + 2;
  localparam int CNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES + 1) : 1;

  localparam logic signed [EXT_W-1:0] POT_MAX = EXT_W'((1 <<< (POT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] POT_MIN = EXT_W'(-(1 <<< (POT_W - 1)));

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic signed [POT_W-1:0]  pot_q, pot_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     spike_q, spike_d;

  logic                     tick;
  logic signed [EXT_W-1:0]  syn_sum;
  logic signed [EXT_W-1:0]  pot_ext;
  logic signed [EXT_W-1:0]  leaked;
  logic signed [EXT_W-1:0]  raw;
  logic signed [EXT_W-1:0]  sat;
  logic signed [EXT_W-1:0]  thr;
  logic                     fire;

  function automatic logic signed [EXT_W-1:0] sext_w(input logic [2:0] w);
    return {{(EXT_W-3){w[2]}}, w};
  endfunction

  // Leak tick is a level taken straight from the selected clockbus line.
  assign tick    = clockbus[decay_sel];
  assign pot_ext = {{(EXT_W-POT_W){pot_q[POT_W-1]}}, pot_q};
  assign thr     = {{(EXT_W-4){1'b0}}, uT};

  // Gated synaptic sum, leak toward zero, then saturate into the potential range.
  always_comb begin
    syn_sum = '0;
    if (spike_in[0]) syn_sum = syn_sum + sext_w(w1);
    if (spike_in[1]) syn_sum = syn_sum + sext_w(w2);
    if (spike_in[2]) syn_sum = syn_sum + sext_w(w3);
    if (spike_in[3]) syn_sum = syn_sum + sext_w(w4);

    leaked = pot_ext;
    if (tick && (pot_ext > 0))      leaked = pot_ext - EXT_W'(1);
    else if (tick && (pot_ext < 0)) leaked = pot_ext + EXT_W'(1);

    raw = leaked + syn_sum;
    if (raw > POT_MAX)      sat = POT_MAX;
    else if (raw < POT_MIN) sat = POT_MIN;
    else                    sat = raw;

    fire = (sat >= thr);
  end

  // State register: full reset here, everything else comes from next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INTEGRATE;
      pot_q   <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pot_q   <= pot_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  // Next-state: network reset, then configuration freeze, then integrate/refract.
  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (reset_nn) begin
      state_d = ST_INTEGRATE;
      pot_d   = '0;
      cnt_d   = '0;
    end else if (!config_en) begin
      case (state_q)
        ST_INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            pot_d   = '0;
            if (REFRACT_CYCLES > 0) begin
              state_d = ST_REFRACT;
              cnt_d   = CNT_W'(REFRACT_CYCLES);
            end
          end else begin
            pot_d = sat[POT_W-1:0];
          end
        end
        ST_REFRACT: begin
          // Counter value 1 marks the last ignored cycle.
          pot_d = '0;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_INTEGRATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_INTEGRATE;
          pot_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: registered spike and potential, busy decoded from state.
  always_comb begin
    spike_out = spike_q;
    pot_out   = pot_q;
    busy      = (state_q == ST_REFRACT);
  end

endmodule
